// File: rtl/pipe_div.sv
// rtl/pipe_div.sv - fully pipelined unsigned restoring divider
//
// Purpose:
//   Computes quotient and remainder of dividend/divisor through a chain of
//   NUM_STAGES identical restoring-division stages. Each stage resolves
//   WIDTH/NUM_STAGES quotient bits per cycle. A new operation may be issued
//   every cycle and there is no stall or backpressure.
//
// Parameters:
//   WIDTH       operand, quotient and remainder width (default 64)
//   NUM_STAGES  pipeline depth and latency in cycles (default 8);
//               must evenly divide WIDTH
//
// Ports:
//   clock      in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   dividend   in   WIDTH  unsigned numerator, sampled when start=1
//   divisor    in   WIDTH  unsigned denominator, sampled when start=1
//   start      in   1      issue an operation this cycle
//   quotient   out  WIDTH  floor(dividend/divisor), valid when done=1
//   remainder  out  WIDTH  dividend mod divisor, valid when done=1
//   done       out  1      result of the op issued NUM_STAGES cycles ago
//   div_zero   out  1      divisor was zero (only with PIPE_DIV_ZERO_FLAG_EN)
//
// Optional feature macro: PIPE_DIV_ZERO_FLAG_EN
//   Adds the div_zero output and a per-stage zero-divisor flag.
//
// Divide by zero needs no special case: the restoring algorithm naturally
// yields quotient = all ones and remainder = dividend.

module pipe_div #(
  parameter int WIDTH      = 64,
  parameter int NUM_STAGES = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             start,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
`ifdef PIPE_DIV_ZERO_FLAG_EN
  output logic             div_zero,
`endif
  output logic             done
);

  localparam int BITS_PER_STAGE = WIDTH / NUM_STAGES;

  if ((WIDTH % NUM_STAGES) != 0) begin : g_bad_params
    $error("pipe_div: NUM_STAGES must evenly divide WIDTH");
  end

  genvar s;
  for (s = 0; s < NUM_STAGES; s++) begin : g_stage
    // Stage inputs: issue ports for stage 0, previous stage registers otherwise.
    logic             in_valid;
    logic [WIDTH-1:0] in_rem;
    logic [WIDTH-1:0] in_quo;
    logic [WIDTH-1:0] in_dsr;

    // Combinational result of this stage's bit steps.
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] quo_d;

    // Stage registers. The stored remainder only needs WIDTH bits: after a
    // restoring step it is always below the divisor, and the next step
    // shifts in from bit WIDTH-1 only. The WIDTH+1 bit working value lives
    // in rem_d, which keeps the compare correct when the divisor MSB is set.
    logic             valid_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;

`ifdef PIPE_DIV_ZERO_FLAG_EN
    logic             in_zf;
    logic             zf_q;
`endif

    if (s == 0) begin : g_entry
      assign in_valid = start;
      assign in_rem   = '0;
      assign in_quo   = dividend;
      assign in_dsr   = divisor;
`ifdef PIPE_DIV_ZERO_FLAG_EN
      assign in_zf    = (divisor == '0);
`endif
    end else begin : g_chain
      assign in_valid = g_stage[s-1].valid_q;
      assign in_rem   = g_stage[s-1].rem_q;
      assign in_quo   = g_stage[s-1].quo_q;
      assign in_dsr   = g_stage[s-1].g_dsr.dsr_q;
`ifdef PIPE_DIV_ZERO_FLAG_EN
      assign in_zf    = g_stage[s-1].zf_q;
`endif
    end

    // Restoring division: shift the next dividend bit into the partial
    // remainder, subtract the divisor when it fits, record the quotient bit
    // in the vacated LSB of the shifting register.
    always_comb begin
      rem_d = {1'b0, in_rem};
      quo_d = in_quo;
      for (int b = 0; b < BITS_PER_STAGE; b++) begin
        rem_d = {rem_d[WIDTH-1:0], quo_d[WIDTH-1]};
        quo_d = {quo_d[WIDTH-2:0], 1'b0};
        if (rem_d >= {1'b0, in_dsr}) begin
          rem_d    = rem_d - {1'b0, in_dsr};
          quo_d[0] = 1'b1;
        end
      end
    end

    // Data registers load unconditionally; valid_q alone qualifies them.
    always_ff @(posedge clock) begin
      if (reset) begin
        valid_q <= 1'b0;
        rem_q   <= '0;
        quo_q   <= '0;
      end else begin
        valid_q <= in_valid;
        rem_q   <= rem_d[WIDTH-1:0];
        quo_q   <= quo_d;
      end
    end

    // The last stage's divisor would never be read, so it is not kept.
    if (s < NUM_STAGES - 1) begin : g_dsr
      logic [WIDTH-1:0] dsr_q;
      always_ff @(posedge clock) begin
        if (reset) begin
          dsr_q <= '0;
        end else begin
          dsr_q <= in_dsr;
        end
      end
    end

`ifdef PIPE_DIV_ZERO_FLAG_EN
    always_ff @(posedge clock) begin
      if (reset) begin
        zf_q <= 1'b0;
      end else begin
        zf_q <= in_zf;
      end
    end
`endif
  end

  assign quotient  = g_stage[NUM_STAGES-1].quo_q;
  assign remainder = g_stage[NUM_STAGES-1].rem_q;
  assign done      = g_stage[NUM_STAGES-1].valid_q;

`ifdef PIPE_DIV_ZERO_FLAG_EN
  // Qualified by done so stale flags in idle slots never show.
  assign div_zero  = g_stage[NUM_STAGES-1].zf_q & g_stage[NUM_STAGES-1].valid_q;
`endif

endmodule

// File: tb/tb_pipe_div.sv
// tb/tb_pipe_div.sv - scoreboard testbench for pipe_div

module tb_pipe_div;

  localparam int W = 64;
  localparam int N = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         done;
`ifdef PIPE_DIV_ZERO_FLAG_EN
  logic         div_zero;
`endif

  pipe_div #(.WIDTH(W), .NUM_STAGES(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .dividend  (dividend),
    .divisor   (divisor),
    .start     (start),
    .quotient  (quotient),
    .remainder (remainder),
`ifdef PIPE_DIV_ZERO_FLAG_EN
    .div_zero  (div_zero),
`endif
    .done      (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  int   ops    = 0;

  always @(posedge clock) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%h required=0x%h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Monitor: every done must match the oldest outstanding op, on its due edge.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done actual=1 required=0 (edge %0d)", edge_n);
      end else begin
        mon_e = sb.pop_front();
        chk("done_latency", W'(edge_n), W'(mon_e.due));
        chk("quotient", quotient, mon_e.q);
        chk("remainder", remainder, mon_e.r);
`ifdef PIPE_DIV_ZERO_FLAG_EN
        chk("div_zero", {63'd0, div_zero}, {63'd0, mon_e.z});
`endif
      end
    end else begin
      if (done !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL done_unknown actual=%b required=0 (edge %0d)", done, edge_n);
      end
      if (sb.size() > 0 && sb[0].due <= edge_n) begin
        mon_e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_done actual=0 required=1 q=0x%h (edge %0d due %0d)",
                 mon_e.q, edge_n, mon_e.due);
      end
`ifdef PIPE_DIV_ZERO_FLAG_EN
      chk("div_zero_idle", {63'd0, div_zero}, 64'd0);
`endif
    end
  end

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Drive one op for one cycle; the reference result comes from plain
  // arithmetic with the divide-by-zero rule applied explicitly.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.z   = (b == '0);
    e.q   = e.z ? {W{1'b1}} : a / b;
    e.r   = e.z ? a : a % b;
    e.due = edge_n + N;
    sb.push_back(e);
    ops++;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      dividend = rnd64();
      divisor  = rnd64();
      start    = 1'b0;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_quotient"}, quotient, 64'd0);
    chk({tag, "_remainder"}, remainder, 64'd0);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           dens;
    int           cyc;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clock);
    #1;
    check_cleared("reset_state");
    reset = 1'b0;
    idle(2);

    // Single op
    issue(64'd100, 64'd7);
    idle(N + 2);

    // Back-to-back
    issue({W{1'b1}}, 64'd1);
    issue(64'd0, 64'd5);
    issue(64'd12345678901, 64'd1000);
    issue(64'd7, 64'd9);
    idle(N + 2);

    // Edge cases
    issue({W{1'b1}}, 64'h8000_0000_0000_0000);
    issue(64'h1234, 64'd0);
    issue(64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(N + 2);

    // Reset mid-flight, with a start coincident with reset
    issue(64'd1000, 64'd3);
    issue(64'd2000, 64'd7);
    issue(64'd3000, 64'd11);
    reset    = 1'b1;
    start    = 1'b1;
    dividend = 64'd99;
    divisor  = 64'd4;
    @(posedge clock);
    #1;
    sb.delete();
    reset = 1'b0;
    start = 1'b0;
    check_cleared("after_reset");
    issue(64'd81, 64'd9);
    idle(N + 2);

    // Gapped issue
    issue(64'd50, 64'd5);
    idle(1);
    issue(64'd51, 64'd5);
    idle(N + 2);

    // Randomised sweep with varying start density
    cyc  = 0;
    dens = 50;
    while (ops < 10100 && cyc < 40000) begin
      if ((cyc % 500) == 0) dens = 20 + 20 * $urandom_range(4);
      if ($urandom_range(99) < dens) begin
        case ($urandom_range(7))
          0:       b = '0;
          1:       b = W'($urandom_range(255, 1));
          2:       b = rnd64();
          default: b = rnd64() >> $urandom_range(63);
        endcase
        if ($urandom_range(5) == 0) a = (b == '0) ? rnd64() : rnd64() % b;
        else                        a = rnd64() >> $urandom_range(40);
        issue(a, b);
      end else begin
        idle(1);
      end
      cyc++;
    end
    idle(N + 4);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 outstanding", sb.size());
    end
    checks++;
    if (ops < 10000) begin
      errors++;
      $display("FAIL op_count actual=%0d required=10000", ops);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_div.md
Name: pipe_div

Overview:
- Fully pipelined unsigned integer divider. Computes quotient and remainder of dividend/divisor.
- Uses the same start/done, one-operation-per-cycle interface as the team's pipelined multiplier. It is that multiplier's inverse-operation counterpart in the ALU.
- A chain of NUM_STAGES identical restoring-division stages. Each stage resolves WIDTH/NUM_STAGES quotient bits per cycle.
- No stall or backpressure; a new operation may be issued every cycle.

Parameters:
- WIDTH, 64: operand, quotient and remainder width in bits.
- NUM_STAGES, 8: pipeline depth and latency in cycles. Must evenly divide WIDTH; elaboration-time error otherwise.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- dividend  input  WIDTH  unsigned numerator, sampled when start=1
- divisor  input  WIDTH  unsigned denominator, sampled when start=1
- start  input  1  issue operation this cycle
- quotient  output  WIDTH  floor(dividend/divisor); valid when done=1
- remainder  output  WIDTH  dividend mod divisor; valid when done=1
- done  output  1  result for the operation issued NUM_STAGES cycles earlier is present

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Both are fixed decisions.
- Reset: on a clock edge with reset=1, every stage's valid bit, partial remainder, partial quotient and divisor register clear to 0. Outputs read quotient=0, remainder=0, done=0 from the next cycle.
- Stage state: valid bit, partial remainder R (WIDTH+1 bits), shifting quotient/dividend register Q (WIDTH bits), divisor D (WIDTH bits).
- Stage 0 entry conditions: R=0, Q=dividend, D=divisor, valid=start.
- Per-bit step, applied WIDTH/NUM_STAGES times combinationally within each stage:
  - R' = {R[WIDTH-1:0], Q[WIDTH-1]}; Q' = {Q[WIDTH-2:0], 0}.
  - If R' >= {0,D}: R' = R' - D and Q'[0] = 1.
- The 65-bit R prevents overflow when D has its MSB set.
- Each stage registers (valid, R, Q, D) every cycle unconditionally. valid propagates the start bit, so data registers may hold garbage when valid=0.
- Outputs: quotient=Q of the last stage; remainder=R[WIDTH-1:0] of the last stage; done=valid of the last stage.
- Latency: start high in the cycle ending at edge t gives done high in the cycle after edge t+NUM_STAGES-1, i.e. exactly NUM_STAGES cycles after issue. done stays high for exactly one cycle per issued op.
- Throughput: 1 op/cycle. Results emerge strictly in issue order, with gaps preserved.
- Divide by zero: no special-case logic. The algorithm yields quotient = all ones and remainder = dividend, and this is the required result.
- dividend < divisor: quotient=0, remainder=dividend.
- Reset mid-operation: all in-flight ops are discarded and never produce done. A start coincident with reset=1 is also discarded.
- start while done is high: independent; no interaction.

Optional Feature:
- Macro: PIPE_DIV_ZERO_FLAG_EN.
- When defined:
  - Adds output port div_zero (1 bit).
  - A per-stage bit, set to (divisor==0) at issue, is pipelined alongside valid.
  - div_zero = last-stage flag AND done. It clears on reset.
  - quotient/remainder values are unchanged: all ones and dividend.
- When undefined: the port and its registers do not exist; all other behaviour is identical.

Test Plan:
- 100/7, start for one cycle, NUM_STAGES=8 -> done exactly 8 cycles later for 1 cycle; quotient=14, remainder=2.
- Four back-to-back ops issued on consecutive cycles -> done high 4 consecutive cycles, in order:
  - (2^64-1)/1 -> q=0xFFFF_FFFF_FFFF_FFFF, r=0
  - 0/5 -> q=0, r=0
  - 12345678901/1000 -> q=12345678, r=901
  - 7/9 -> q=0, r=7
- Edge cases:
  - (2^64-1)/2^63 -> q=1, r=2^63-1.
  - 0x1234/0 -> q=0xFFFF_FFFF_FFFF_FFFF, r=0x1234; div_zero=1 with done when PIPE_DIV_ZERO_FLAG_EN is defined, otherwise the port is absent.
- Reset mid-flight: issue 3 ops, assert reset for 1 cycle at cycle 3 -> done never asserts for them; quotient=remainder=0 after reset. An op issued the cycle after reset deasserts completes normally 8 cycles later.
- Gapped issue: start pattern 1,0,1 with 50/5 and 51/5 -> done pattern 1,0,1 after 8 cycles; results q=10,r=0 then q=10,r=1.
- Randomised sweep, ≥10k ops with random start density, compared against a reference model -> every done matches the q/r of the op issued 8 cycles earlier.
